// File: rtl/tick_led_counter.sv
// Tick-qualified LED up/down counter with synchronised, debounced direction buttons and a hold switch.
// Optional build macro TICK_LED_COUNTER_SATURATE_EN: pin at the limits and stop instead of wrapping.
module tick_led_counter #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             sw_hold,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             dir_up,
    output logic             wrap
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
`ifdef TICK_LED_COUNTER_SATURATE_EN
    localparam logic [WIDTH-1:0] CNT_MAX_M1 = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
`endif

    typedef enum logic [1:0] {STOP, UP, DOWN} state_t;

    // Bit 0 = up button, bit 1 = down button, bit 2 = hold switch.
    logic [2:0]          s1_q, s2_q;
    logic [1:0]          db_q, db_dly_q;
    logic [1:0][DW-1:0]  dcnt_q;
    logic [1:0]          rise;
    logic                hold_s;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic                wrap_q, wrap_d;
    logic                running_q, dir_up_q;
`ifdef TICK_LED_COUNTER_SATURATE_EN
    logic                pin;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            dcnt_q   <= '0;
        end else begin
            s1_q     <= {sw_hold, btn_down, btn_up};
            s2_q     <= s1_q;
            db_dly_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == db_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DCNT_LAST) begin
                    db_q[i]   <= s2_q[i];
                    dcnt_q[i] <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise   = db_q & ~db_dly_q;
    assign hold_s = s2_q[2];

    // Count step uses the registered (pre-transition) state.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
`ifdef TICK_LED_COUNTER_SATURATE_EN
        pin     = 1'b0;
`endif
        if (tick_en && !hold_s) begin
            case (state_q)
                UP: begin
                    if (count_q == '1) begin
`ifndef TICK_LED_COUNTER_SATURATE_EN
                        count_d = '0;
                        wrap_d  = 1'b1;
`endif
                    end else begin
                        count_d = count_q + 1'b1;
`ifdef TICK_LED_COUNTER_SATURATE_EN
                        if (count_q == CNT_MAX_M1) begin
                            wrap_d = 1'b1;
                            pin    = 1'b1;
                        end
`endif
                    end
                end
                DOWN: begin
                    if (count_q == '0) begin
`ifndef TICK_LED_COUNTER_SATURATE_EN
                        count_d = '1;
                        wrap_d  = 1'b1;
`endif
                    end else begin
                        count_d = count_q - 1'b1;
`ifdef TICK_LED_COUNTER_SATURATE_EN
                        if (count_q == CNT_ONE) begin
                            wrap_d = 1'b1;
                            pin    = 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (rise)
            2'b01:   state_d = UP;
            2'b10:   state_d = DOWN;
            2'b11:   state_d = STOP;
            default: state_d = state_q;
        endcase
`ifdef TICK_LED_COUNTER_SATURATE_EN
        // Reaching a limit stops the counter on that same edge.
        if (pin) state_d = STOP;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= STOP;
            running_q <= 1'b0;
            dir_up_q  <= 1'b0;
            count_q   <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d != STOP);
            dir_up_q  <= (state_d == UP);
            count_q   <= count_d;
            wrap_q    <= wrap_d;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign dir_up  = dir_up_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_tick_led_counter.sv
// Directed bench for tick_led_counter (WIDTH=4, DEBOUNCE_CYCLES=4); expectations follow TICK_LED_COUNTER_SATURATE_EN.
module tb_tick_led_counter;

    logic       clk = 1'b0;
    logic       reset, tick_en, btn_up, btn_down, sw_hold;
    logic [3:0] count;
    logic       running, dir_up, wrap;

    int n_checks = 0;
    int n_fail   = 0;

    tick_led_counter #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick_en  (tick_en),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .sw_hold  (sw_hold),
        .count    (count),
        .running  (running),
        .dir_up   (dir_up),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic tick();
        tick_en = 1'b1;
        step();
        tick_en = 1'b0;
        step(7);
    endtask

    task automatic press(input logic up, input logic dn);
        btn_up   = up;
        btn_down = dn;
        step(8);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        step(8);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset    = 1'b1;
        tick_en  = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        sw_hold  = 1'b0;
        step(2);
        chk("rst_count", count, 0);
        chk("rst_running", running, 0);
        chk("rst_wrap", wrap, 0);
        reset = 1'b0;
        step();

        // Debounce latency: UP appears on the 7th edge after the button is first sampled.
        btn_up = 1'b1;
        step(6);
        chk("db_lat_early", running, 0);
        step();
        chk("db_lat_running", running, 1);
        chk("db_lat_dir_up", dir_up, 1);
        btn_up = 1'b0;
        step(8);

        for (int i = 0; i < 9; i++) tick();
        chk("count_9", count, 9);

        // Asynchronous reset mid-run.
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_running", running, 0);
        chk("async_rst_dir_up", dir_up, 0);
        chk("async_rst_wrap", wrap, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        tick();
        tick();
        chk("after_rst_idle", count, 0);

        // A 3-cycle glitch must not be accepted.
        btn_up = 1'b1;
        step(3);
        btn_up = 1'b0;
        step(10);
        chk("glitch_running", running, 0);

        // Up to 14, then across the top.
        press(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        chk("count_14", count, 14);
        tick_en = 1'b1;
        step();
        tick_en = 1'b0;
        chk("up_15", count, 15);
`ifdef TICK_LED_COUNTER_SATURATE_EN
        chk("sat_wrap_14_15", wrap, 1);
        chk("sat_running", running, 0);
`else
        chk("up_wrap_at_15", wrap, 0);
`endif
        step();
        chk("up_wrap_after_15", wrap, 0);
        step(6);
        tick_en = 1'b1;
        step();
        tick_en = 1'b0;
`ifdef TICK_LED_COUNTER_SATURATE_EN
        chk("sat_hold_15", count, 15);
        chk("sat_wrap_pinned", wrap, 0);
        chk("sat_running_2", running, 0);
        step(7);
        tick();
        chk("sat_hold_15_b", count, 15);
`else
        chk("up_roll_0", count, 0);
        chk("up_roll_wrap", wrap, 1);
        step();
        chk("up_roll_wrap_clr", wrap, 0);
`endif

        // Down from zero, then a simultaneous press.
        do_reset();
        press(1'b0, 1'b1);
        chk("down_running", running, 1);
        chk("down_dir_up", dir_up, 0);
        tick_en = 1'b1;
        step();
        tick_en = 1'b0;
`ifdef TICK_LED_COUNTER_SATURATE_EN
        chk("down_sat_0", count, 0);
        chk("down_sat_wrap", wrap, 0);
`else
        chk("down_roll_15", count, 15);
        chk("down_roll_wrap", wrap, 1);
`endif
        step();
        chk("down_wrap_clr", wrap, 0);
        step(6);
        press(1'b1, 1'b1);
        chk("both_running", running, 0);
        chk("both_dir_up", dir_up, 0);
        tick();
        tick();
`ifdef TICK_LED_COUNTER_SATURATE_EN
        chk("both_count_frozen", count, 0);
`else
        chk("both_count_frozen", count, 15);
`endif

        // Hold switch.
        do_reset();
        press(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("hold_pre", count, 5);
        sw_hold = 1'b1;
        step(2);
        for (int i = 0; i < 3; i++) begin
            tick_en = 1'b1;
            step();
            tick_en = 1'b0;
            chk("hold_count", count, 5);
            chk("hold_wrap", wrap, 0);
            step(7);
        end
        press(1'b0, 1'b1);
        chk("hold_dir_up", dir_up, 0);
        chk("hold_running", running, 1);
        sw_hold = 1'b0;
        step(2);
        tick_en = 1'b1;
        step();
        tick_en = 1'b0;
        chk("unhold_count", count, 4);

        // Consecutive tick_en cycles each count.
        step(3);
        tick_en = 1'b1;
        step(3);
        tick_en = 1'b0;
        chk("multi_tick", count, 1);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
